// File: rtl/lcd_pkg.sv
// Shared types for the LCD refresh arbiter: panel status codes,
// arbiter FSM states and VRAM write-port widths.
package lcd_pkg;

   localparam int ROW_W  = 7;
   localparam int COL_W  = 2;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      LCD_INIT   = 2'd0,
      LCD_READY  = 2'd1,
      LCD_BUSY   = 2'd2,
      LCD_FINISH = 2'd3
   } lcd_status_t;

   typedef enum logic [1:0] {
      S_WAIT_INIT = 2'd0,
      S_IDLE      = 2'd1,
      S_REFRESH   = 2'd2,
      S_RELEASE   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin picker with its pointer flop.
// Ports: clk, rst (async, active-high), en, req[1:0] -> gnt[1:0] (one-hot or 0).
module lcd_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // High when port B should win a tie (A was granted last).
   logic prefer_b;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req[0] && (!req[1] || !prefer_b))
            gnt = 2'b01;
         else if (req[1])
            gnt = 2'b10;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         prefer_b <= 1'b0;
      else if (|gnt)
         prefer_b <= gnt[0];
   end

endmodule

// File: rtl/lcd_refresh_arbiter.sv
// Arbitrates lcd_top VRAM writes between ports A/B and owns I_refresh.
// Ports: clk, rst; a_*/b_* req/row/col/data/ack; sw_refresh; lcd_status;
//   lcd_vram_we/row/col/data, lcd_refresh; busy, dirty, frame_cnt.
// Optional: LCD_ARB_AUTO_REFRESH_EN enables the dirty-gated refresh timer.
module lcd_refresh_arbiter
   import lcd_pkg::*;
#(
   parameter int REFRESH_PERIOD = 5_000_000,
   parameter int TIMER_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic [ROW_W-1:0]  a_row,
   input  logic [COL_W-1:0]  a_col,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ack,
   input  logic              b_req,
   input  logic [ROW_W-1:0]  b_row,
   input  logic [COL_W-1:0]  b_col,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ack,
   input  logic              sw_refresh,
   input  logic [1:0]        lcd_status,
   output logic              lcd_vram_we,
   output logic [ROW_W-1:0]  lcd_row,
   output logic [COL_W-1:0]  lcd_col,
   output logic [DATA_W-1:0] lcd_data,
   output logic              lcd_refresh,
   output logic              busy,
   output logic              dirty,
   output logic [15:0]       frame_cnt
);

   arb_state_t  state;
   lcd_status_t status;
   logic        pending;
   logic        timer_fire;
   logic        refresh_req;
   logic        grant_en;
   logic        refresh_go;
   logic        st_ready;
   logic        st_finish;
   logic [1:0]  elig;
   logic [1:0]  gnt;

   logic [ROW_W-1:0]  w_row;
   logic [COL_W-1:0]  w_col;
   logic [DATA_W-1:0] w_data;

   assign status    = lcd_status_t'(lcd_status);
   assign st_ready  = (status == LCD_READY);
   assign st_finish = (status == LCD_FINISH);

   // A request arriving this very cycle already blocks writes, so a
   // simultaneous sw_refresh and req resolves in favour of the refresh.
   assign refresh_req = pending | sw_refresh | timer_fire;
   assign grant_en    = (state == S_IDLE) & st_ready & ~refresh_req;
   // Never start a refresh while a write is on the VRAM port.
   assign refresh_go  = (state == S_IDLE) & refresh_req & ~lcd_vram_we;

   // A port is ineligible in its own ack cycle.
   assign elig = {b_req & ~b_ack, a_req & ~a_ack};

   lcd_rr_arb2 u_rr (
      .clk (clk),
      .rst (rst),
      .en  (grant_en),
      .req (elig),
      .gnt (gnt)
   );

   always_comb begin
      w_row  = a_row;
      w_col  = a_col;
      w_data = a_data;
      unique case (1'b1)
         gnt[1]: begin
            w_row  = b_row;
            w_col  = b_col;
            w_data = b_data;
         end
         default: ;
      endcase
   end

`ifdef LCD_ARB_AUTO_REFRESH_EN
   localparam logic [TIMER_W-1:0] T_LAST = TIMER_W'(REFRESH_PERIOD - 1);

   logic [TIMER_W-1:0] timer;
   logic               t_wrap;

   assign t_wrap     = (state == S_IDLE) && (timer == T_LAST);
   assign timer_fire = t_wrap & dirty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         timer <= '0;
      else if (state == S_IDLE)
         timer <= t_wrap ? '0 : timer + TIMER_W'(1);
   end
`else
   logic unused_cfg;

   assign timer_fire = 1'b0;
   assign unused_cfg = ^{32'(REFRESH_PERIOD), 32'(TIMER_W)};
`endif

   // busy is registered so every output reads 0 while in reset; it
   // follows the state register from the first clock onward.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_WAIT_INIT;
         pending     <= 1'b0;
         a_ack       <= 1'b0;
         b_ack       <= 1'b0;
         lcd_vram_we <= 1'b0;
         lcd_row     <= '0;
         lcd_col     <= '0;
         lcd_data    <= '0;
         lcd_refresh <= 1'b0;
         busy        <= 1'b0;
         dirty       <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         lcd_vram_we <= |gnt;
         a_ack       <= gnt[0];
         b_ack       <= gnt[1];
         if (|gnt) begin
            lcd_row  <= w_row;
            lcd_col  <= w_col;
            lcd_data <= w_data;
            dirty    <= 1'b1;
         end

         if (refresh_go)
            pending <= 1'b0;
         else if (refresh_req)
            pending <= 1'b1;

         unique case (state)
            S_WAIT_INIT: begin
               busy <= ~st_ready;
               if (st_ready)
                  state <= S_IDLE;
            end
            S_IDLE: begin
               busy <= refresh_go;
               if (refresh_go) begin
                  state       <= S_REFRESH;
                  lcd_refresh <= 1'b1;
                  dirty       <= 1'b0;
               end
            end
            S_REFRESH: begin
               busy <= 1'b1;
               if (st_finish) begin
                  state       <= S_RELEASE;
                  lcd_refresh <= 1'b0;
                  frame_cnt   <= frame_cnt + 16'd1;
               end
            end
            S_RELEASE: begin
               busy <= ~st_ready;
               if (st_ready)
                  state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/lcd_refresh_arbiter.md
# lcd_refresh_arbiter

Shares the `lcd_top` VRAM write port between two requesters: port A for the CPU MMIO path and port B for the text/console engine. It also owns the `I_refresh` handshake. Writes are allowed only while the LCD reports READY. Refresh is started on a software pulse or, optionally, by a periodic timer when VRAM is dirty. The block sits between the bus/console logic and `lcd_top`, and is the only driver of `lcd_top`'s `I_vram_we`, `I_row`, `I_col`, `I_data` and `I_refresh`.

## Interface
- `REFRESH_PERIOD`, 5_000_000: auto-refresh interval in clk cycles; must be ≥ 2.
- `TIMER_W`, 32: width of the refresh timer.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `a_req` in 1: port A write request; held until `a_ack`.
- `a_row` in 7 / `a_col` in 2 / `a_data` in 32: port A VRAM row, 32-bit column word, data.
- `a_ack` out 1: one-cycle pulse; the write was issued.
- `b_req`, `b_row`, `b_col`, `b_data`, `b_ack`: same as port A, for port B.
- `sw_refresh` in 1: single-cycle refresh request.
- `lcd_status` in 2: `lcd_top` `O_status` (0 INIT, 1 READY, 2 BUSY, 3 FINISH).
- `lcd_vram_we` out 1 / `lcd_row` out 7 / `lcd_col` out 2 / `lcd_data` out 32: drive `lcd_top` `I_vram_we`, `I_row`, `I_col`, `I_data`.
- `lcd_refresh` out 1: drives `I_refresh`.
- `busy` out 1: high in any state other than S_IDLE.
- `dirty` out 1: a write has occurred since the last refresh start.
- `frame_cnt` out 16: number of completed refreshes; wraps at 16 bits.

## Operation
- **State machine:**
  - **S_WAIT_INIT → S_IDLE** when `lcd_status`=READY.
  - **S_IDLE → S_REFRESH** when `pending` is set and no write is issuing this cycle. On entry: `lcd_refresh`←1, `pending`←0, `dirty`←0.
  - **S_REFRESH → S_RELEASE** when `lcd_status`=FINISH. On this transition: `lcd_refresh`←0, `frame_cnt`++.
  - **S_RELEASE → S_IDLE** when `lcd_status`=READY.
- **`pending`:** set by `sw_refresh` in any state, or by timer expiry. Requests arriving during S_REFRESH or S_RELEASE are kept and served after return to S_IDLE. Multiple requests collapse into one.
- **Arbitration:** allowed only in S_IDLE with `lcd_status`=READY and `pending`=0. A refresh pending always wins over writes.
  - Eligible port = `req` high and that port not acked in the current cycle.
  - Two eligible ports: round-robin. The port not granted last wins; after reset, A wins first.
- **Write issue:** the granted port's row, col and data are registered into `lcd_*` with `lcd_vram_we`=1 for exactly one cycle. The same-cycle `x_ack` pulses and `dirty`←1.
- **Reset values:** all outputs 0, state S_WAIT_INIT, `pending`=0, round-robin pointer favours A, timer 0.
- **Reset mid-refresh:** `lcd_refresh` drops immediately and the block restarts in S_WAIT_INIT. `lcd_top` then returns FINISH→READY by its own handshake.

## Timing
- **Write latency:** `req` sampled high at edge t → `lcd_vram_we` and `ack` high in cycle t+1. Requesters must hold row, col and data stable until `ack`.
- **Throughput:**
  - A single port writes at most every 2 cycles, because it is ineligible in its ack cycle.
  - Alternating A/B requests achieve 1 write per cycle.
- **Refresh timing:** `sw_refresh` in S_IDLE with no write in flight → `lcd_refresh` high on the next cycle. It stays high until the cycle after FINISH is sampled.
- **Status stability:** `lcd_status` cannot leave READY without `lcd_refresh`, so a grant decided on READY remains valid in the issue cycle.
- **Simultaneous events:** `sw_refresh` and a `req` arriving together in S_IDLE → the write is blocked and the refresh starts. The write is granted after return to S_IDLE.

## Configuration
- **`LCD_ARB_AUTO_REFRESH_EN` defined:**
  - The timer counts in S_IDLE only and holds otherwise.
  - At `REFRESH_PERIOD`-1 the timer wraps to 0 and sets `pending` if `dirty`=1.
  - A clean screen is never auto-refreshed.
- **Undefined:** no timer logic exists. Refresh comes from `sw_refresh` only, and `REFRESH_PERIOD`/`TIMER_W` are unused.

## Structure
- **Package `lcd_pkg`:**
  - `lcd_status_t`: INIT/READY/BUSY/FINISH, 2-bit encoding 0–3.
  - Arbiter state enum.
  - Widths: ROW_W=7, COL_W=2, DATA_W=32.
- **Sub-module `lcd_rr_arb2`:** a combinational two-way round-robin picker plus its pointer flop.

## Test plan
- **Init gating:** hold `lcd_status`=0 for 100 cycles with `a_req`=1 → no `lcd_vram_we`, `a_ack`=0. Set status=1 → `a_ack`, `lcd_vram_we` pulse 2 cycles later with row/col/data = A's values.
- **Round-robin:** A and B requesting continuously → issue order A,B,A,B with `lcd_vram_we` high every cycle. B alone → a write every 2nd cycle.
- **Refresh handshake:**
  - `sw_refresh` pulse in S_IDLE → `lcd_refresh`=1 next cycle.
  - Status 2 then 3 → `lcd_refresh` drops, `frame_cnt`=1.
  - Status 1 → `busy`=0.
- **Collision:** `sw_refresh` and `a_req` in the same cycle → refresh wins. `a_ack` appears only after status returns to 1, and `dirty`=1 afterwards.
- **Auto refresh:** with `LCD_ARB_AUTO_REFRESH_EN` and `REFRESH_PERIOD`=16:
  - Idle with `dirty`=0 → no refresh for 100 cycles.
  - One write → `lcd_refresh` within 16 cycles.
- **Reset during S_REFRESH:** all outputs 0 asynchronously, then S_WAIT_INIT until status=1.
